// File: rtl/sevseg_scan_ndigit.sv
// N-digit multiplexed seven-segment scanner with per-digit dp/blank/blink,
// leading-zero suppression, 16-level dimming and frame-synchronous load/ack.
module sevseg_scan_ndigit #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV_W = 16,
  parameter int BLINK_W    = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic [6:0]              glyph,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  input  logic                    load,
  output logic                    load_ack,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_DIV_W-1:0]   r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic [BLINK_W-1:0]      r_blink;
  logic [4*NUM_DIGITS-1:0] r_sh_digits, r_act_digits;
  logic [NUM_DIGITS-1:0]   r_sh_dp, r_act_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank, r_act_blank;
  logic [NUM_DIGITS-1:0]   r_sh_blink, r_act_blink;
  logic                    r_pending;
  logic                    r_load_ack;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_presc_max;
  logic                    w_boundary;
  logic [3:0]              w_code;
  logic [NUM_DIGITS-1:0]   w_lz_dark;
  logic                    w_higher_zero;
  logic                    w_dark;
  logic                    w_on;
  logic [NUM_DIGITS-1:0]   w_an_sel;

  function automatic logic [6:0] f_decode(input logic [3:0] code, input logic [6:0] glyph_pat);
    case (code)
      4'd0:    f_decode = 7'b1000000;
      4'd1:    f_decode = 7'b1111001;
      4'd2:    f_decode = 7'b0100100;
      4'd3:    f_decode = 7'b0110000;
      4'd4:    f_decode = 7'b0011001;
      4'd5:    f_decode = 7'b0010010;
      4'd6:    f_decode = 7'b0000010;
      4'd7:    f_decode = 7'b1111000;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0010000;
      default: f_decode = glyph_pat;
    endcase
  endfunction

  assign w_presc_max = &r_presc;
  assign w_boundary  = w_presc_max & (r_idx == LAST_IDX);
  assign w_code      = r_act_digits[{r_idx, 2'b00} +: 4];

  // Scan from the top digit down; a zero stays suppressed only while everything above it is zero or blank.
  always_comb begin
    w_lz_dark     = '0;
    w_higher_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_lz_dark[i]  = lz_suppress & (r_act_digits[4*i +: 4] == 4'd0) & w_higher_zero;
      w_higher_zero = w_higher_zero & ((r_act_digits[4*i +: 4] == 4'd0) | r_act_blank[i]);
    end
  end

  assign w_dark   = r_act_blank[r_idx] | w_lz_dark[r_idx] | (r_act_blink[r_idx] & r_blink[BLINK_W-1]);
  assign w_on     = (r_presc[SCAN_DIV_W-1 -: 4] <= brightness);
  assign w_an_sel = ~(NUM_DIGITS'(1) << r_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_blink <= '0;
    end else begin
      r_presc <= r_presc + SCAN_DIV_W'(1);
      r_blink <= r_blink + BLINK_W'(1);
      if (w_presc_max) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // Shadow takes loads at any time; active only changes on the frame boundary so a frame never mixes data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_digits  <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '1;
      r_sh_blink   <= '0;
      r_act_digits <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '1;
      r_act_blink  <= '0;
      r_pending    <= 1'b0;
      r_load_ack   <= 1'b0;
    end else begin
      r_load_ack <= w_boundary & r_pending;
      if (w_boundary && r_pending) begin
        r_act_digits <= r_sh_digits;
        r_act_dp     <= r_sh_dp;
        r_act_blank  <= r_sh_blank;
        r_act_blink  <= r_sh_blink;
      end
      if (load) begin
        r_sh_digits <= digits;
        r_sh_dp     <= dp_in;
        r_sh_blank  <= blank_in;
        r_sh_blink  <= blink_in;
        r_pending   <= 1'b1;
      end else if (w_boundary) begin
        r_pending   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
      r_an  <= '1;
    end else begin
      r_seg <= w_dark ? 7'h7F : f_decode(w_code, glyph);
      r_dp  <= w_dark ? 1'b1 : ~r_act_dp[r_idx];
      r_an  <= w_on ? w_an_sel : '1;
    end
  end

  assign load_ack = r_load_ack;
  assign seg      = r_seg;
  assign dp       = r_dp;
  assign an       = r_an;

endmodule
